// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding and default datapath widths
// used by fetch, decode and the register file.
package cpu_pkg;

  localparam int unsigned CPU_ADDR_W = 8;
  localparam int unsigned CPU_DATA_W = 16;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_VALID = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: req/ready handshake with word address and data.
interface fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = CPU_ADDR_W,
  parameter int unsigned DATA_W = CPU_DATA_W
) ();

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ready, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ready, output mem_rdata);

endinterface

// File: rtl/fetch_unit_pc_counter.sv
// Program counter with async reset, load-over-increment priority and wrap.
module pc_counter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = CPU_ADDR_W,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= ADDR_W'(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory, loads the
// external instruction register and hands instructions to decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = CPU_ADDR_W,
  parameter int unsigned DATA_W   = CPU_DATA_W,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_unit_if.master      mem,
  output logic              ir_we,
  output logic [DATA_W-1:0] ir_data,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ack,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target
);

  fetch_state_e      state_d, state_q;
  logic              instr_valid_d, instr_valid_q;
  logic [ADDR_W-1:0] instr_pc_d, instr_pc_q;
  logic              fire_c;
  logic [ADDR_W-1:0] pc;

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (fire_c),
    .load     (branch_taken),
    .load_val (branch_target),
    .pc       (pc)
  );

  // Branch outranks everything: it drops any coinciding response and any pending instruction.
  always_comb begin
    state_d       = state_q;
    instr_valid_d = instr_valid_q;
    instr_pc_d    = instr_pc_q;
    fire_c        = 1'b0;
    case (state_q)
      FETCH_IDLE: begin
        state_d = FETCH_REQ;
      end
      FETCH_REQ: begin
        if (branch_taken) begin
          state_d = FETCH_REQ;
        end else if (mem.mem_ready) begin
          fire_c        = 1'b1;
          state_d       = FETCH_VALID;
          instr_valid_d = 1'b1;
          instr_pc_d    = pc;
        end
      end
      FETCH_VALID: begin
        if (branch_taken || (instr_ack && !stall)) begin
          state_d       = FETCH_REQ;
          instr_valid_d = 1'b0;
        end
      end
      default: begin
        state_d       = FETCH_IDLE;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH_IDLE;
      instr_valid_q <= 1'b0;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      instr_valid_q <= instr_valid_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  // Request follows state, so an async reset drops it without waiting for an edge.
  assign mem.mem_req  = (state_q == FETCH_REQ);
  assign mem.mem_addr = pc;
  assign ir_we        = fire_c;
  assign ir_data      = mem.mem_rdata;
  assign instr_valid  = instr_valid_q;
  assign instr_pc     = instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector table plus a scoreboard
// of fetched {pc, word} pairs checked when instructions reach decode.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ir_we;
  logic [15:0] ir_data;
  logic        instr_valid;
  logic [7:0]  instr_pc;
  logic        instr_ack;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [15:0] ir_q;

  int tests = 0;
  int fails = 0;

  fetch_unit_if #(.ADDR_W(8), .DATA_W(16)) mem_if ();

  fetch_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem           (mem_if),
    .ir_we         (ir_we),
    .ir_data       (ir_data),
    .instr_valid   (instr_valid),
    .instr_pc      (instr_pc),
    .instr_ack     (instr_ack),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target)
  );

  always #5 clk = ~clk;

  // Stand-in for the downstream instruction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ir_q <= 16'h0000;
    else if (ir_we) ir_q <= ir_data;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(mem_if.mem_ready && !mem_if.mem_req))
      else begin
        fails++;
        $display("FAIL mem_ready_without_req: mem_ready=1 while mem_req=0");
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ready;
    logic [15:0] rdata;
    logic        ack;
    logic        st;
    logic        br;
    logic [7:0]  tgt;
    logic        exp_req;
    logic [7:0]  exp_addr;
    logic        exp_we;
    logic        exp_valid;
    logic [7:0]  exp_ipc;
    logic [15:0] exp_ir;
  } vec_t;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] word;
  } sb_t;

  function automatic vec_t mk(logic rdy, logic [15:0] rd, logic ack, logic st, logic br,
                              logic [7:0] tg, logic er, logic [7:0] ea, logic ew,
                              logic ev, logic [7:0] eipc, logic [15:0] eir);
    vec_t v;
    v.ready = rdy; v.rdata = rd; v.ack = ack; v.st = st; v.br = br; v.tgt = tg;
    v.exp_req = er; v.exp_addr = ea; v.exp_we = ew; v.exp_valid = ev;
    v.exp_ipc = eipc; v.exp_ir = eir;
    return v;
  endfunction

  vec_t vecs[22];
  sb_t  sbq[$];
  sb_t  sb;
  logic prev_valid;
  logic got_req;

  initial begin
    // ready rdata ack stall br tgt | req addr we valid ipc ir
    vecs[0]  = mk(0, 16'h0000, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 16'h0000); // IDLE bubble
    vecs[1]  = mk(1, 16'hA001, 0, 0, 0, 8'h00, 1, 8'h00, 1, 0, 8'h00, 16'h0000); // first fetch
    vecs[2]  = mk(0, 16'h0000, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h00, 16'hA001);
    vecs[3]  = mk(0, 16'h0000, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h00, 16'hA001); // ack
    vecs[4]  = mk(0, 16'h0000, 0, 0, 0, 8'h00, 1, 8'h01, 0, 0, 8'h00, 16'hA001); // wait states
    vecs[5]  = mk(0, 16'h0000, 0, 0, 0, 8'h00, 1, 8'h01, 0, 0, 8'h00, 16'hA001);
    vecs[6]  = mk(0, 16'h0000, 0, 0, 0, 8'h00, 1, 8'h01, 0, 0, 8'h00, 16'hA001);
    vecs[7]  = mk(1, 16'hB002, 0, 0, 0, 8'h00, 1, 8'h01, 1, 0, 8'h00, 16'hA001);
    vecs[8]  = mk(0, 16'h0000, 1, 1, 0, 8'h00, 0, 8'h00, 0, 1, 8'h01, 16'hB002); // stalled
    vecs[9]  = mk(0, 16'h0000, 1, 1, 0, 8'h00, 0, 8'h00, 0, 1, 8'h01, 16'hB002);
    vecs[10] = mk(0, 16'h0000, 1, 1, 0, 8'h00, 0, 8'h00, 0, 1, 8'h01, 16'hB002);
    vecs[11] = mk(0, 16'h0000, 1, 1, 0, 8'h00, 0, 8'h00, 0, 1, 8'h01, 16'hB002);
    vecs[12] = mk(0, 16'h0000, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h01, 16'hB002);
    vecs[13] = mk(1, 16'hC003, 0, 0, 1, 8'h40, 1, 8'h02, 0, 0, 8'h01, 16'hB002); // branch vs ready
    vecs[14] = mk(0, 16'h0000, 0, 0, 0, 8'h00, 1, 8'h40, 0, 0, 8'h01, 16'hB002);
    vecs[15] = mk(1, 16'hD004, 0, 0, 0, 8'h00, 1, 8'h40, 1, 0, 8'h01, 16'hB002);
    vecs[16] = mk(0, 16'h0000, 1, 0, 1, 8'hFF, 0, 8'h00, 0, 1, 8'h40, 16'hD004); // branch in VALID
    vecs[17] = mk(1, 16'hE005, 0, 0, 0, 8'h00, 1, 8'hFF, 1, 0, 8'h40, 16'hD004);
    vecs[18] = mk(0, 16'h0000, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'hFF, 16'hE005);
    vecs[19] = mk(0, 16'h0000, 0, 1, 0, 8'h00, 1, 8'h00, 0, 0, 8'hFF, 16'hE005); // wrapped, stall in REQ
    vecs[20] = mk(1, 16'hF006, 0, 1, 0, 8'h00, 1, 8'h00, 1, 0, 8'hFF, 16'hE005);
    vecs[21] = mk(0, 16'h0000, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h00, 16'hF006);

    rst_n = 1'b0;
    instr_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    mem_if.mem_ready = 1'b0; mem_if.mem_rdata = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mem_req", 32'(mem_if.mem_req), 32'd0);
    chk("reset_ir_we", 32'(ir_we), 32'd0);
    chk("reset_instr_valid", 32'(instr_valid), 32'd0);
    chk("reset_instr_pc", 32'(instr_pc), 32'd0);
    rst_n = 1'b1;
    prev_valid = 1'b0;

    foreach (vecs[i]) begin
      mem_if.mem_ready = vecs[i].ready;
      mem_if.mem_rdata = vecs[i].rdata;
      instr_ack = vecs[i].ack;
      stall = vecs[i].st;
      branch_taken = vecs[i].br;
      branch_target = vecs[i].tgt;
      @(negedge clk);
      chk($sformatf("v%0d_mem_req", i), 32'(mem_if.mem_req), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req)
        chk($sformatf("v%0d_mem_addr", i), 32'(mem_if.mem_addr), 32'(vecs[i].exp_addr));
      chk($sformatf("v%0d_ir_we", i), 32'(ir_we), 32'(vecs[i].exp_we));
      chk($sformatf("v%0d_instr_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_instr_pc", i), 32'(instr_pc), 32'(vecs[i].exp_ipc));
      chk($sformatf("v%0d_ir", i), 32'(ir_q), 32'(vecs[i].exp_ir));
      if (vecs[i].exp_we) begin
        sb.pc = vecs[i].exp_addr;
        sb.word = vecs[i].rdata;
        sbq.push_back(sb);
      end
      if (instr_valid && !prev_valid) begin
        if (sbq.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb_unexpected_instr: pc %h with no fetch outstanding", instr_pc);
        end else begin
          sb = sbq.pop_front();
          chk("sb_instr_pc", 32'(instr_pc), 32'(sb.pc));
          chk("sb_ir_word", 32'(ir_q), 32'(sb.word));
        end
      end
      prev_valid = instr_valid;
      @(posedge clk);
      #1;
    end
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    mem_if.mem_ready = 1'b0;
    instr_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0;

    // Reset pulsed in the middle of an outstanding request.
    instr_ack = 1'b1;
    @(posedge clk); #1;
    instr_ack = 1'b0;
    #2;
    chk("midreq_mem_req_before", 32'(mem_if.mem_req), 32'd1);
    chk("midreq_mem_addr_before", 32'(mem_if.mem_addr), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreq_mem_req_async", 32'(mem_if.mem_req), 32'd0);
    chk("midreq_instr_valid_async", 32'(instr_valid), 32'd0);
    chk("midreq_instr_pc_async", 32'(instr_pc), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_idle_bubble", 32'(mem_if.mem_req), 32'd0);
    got_req = 1'b0;
    for (int n = 0; n < 4 && !got_req; n++) begin
      @(negedge clk);
      got_req = mem_if.mem_req;
    end
    chk("restart_req_seen", 32'(got_req), 32'd1);
    chk("restart_addr", 32'(mem_if.mem_addr), 32'd0);
    mem_if.mem_rdata = 16'h1234;
    mem_if.mem_ready = got_req;
    @(posedge clk); #1;
    mem_if.mem_ready = 1'b0;
    @(negedge clk);
    chk("restart_instr_valid", 32'(instr_valid), 32'd1);
    chk("restart_instr_pc", 32'(instr_pc), 32'd0);
    chk("restart_ir", 32'(ir_q), 32'h1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
